uart_rx_fifo: RTL

//  Buffered UART receiver: 8N1 frames (optional even parity) recovered from i_rx with 2-flop

---
 rtl/uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffered 8N1 UART receiver feeding a first-word-fall-through FIFO.
// The serial line passes through a 2-flop synchroniser. Each bit is the majority vote of
// three samples taken around mid-bit.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
// Framing and parity errors are reported as 1-cycle pulses.
// A byte dropped on a full FIFO sets the sticky o_overflow flag.
module uart_rx_fifo #(
    parameter int unsigned clks_per_bit = 543,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rx,
    input  logic                     i_data_ack,
    output logic                     o_data_avail,
    output logic [7:0]               o_databyte,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_frame_err,
    output logic                     o_parity_err,
    output logic                     o_overflow
);

    localparam int unsigned CntW = $clog2(clks_per_bit);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned Mid  = clks_per_bit / 2;

    localparam logic [CntW-1:0] CntSampA = CntW'(Mid - 1);
    localparam logic [CntW-1:0] CntSampB = CntW'(Mid);
    localparam logic [CntW-1:0] CntVote  = CntW'(Mid + 1);
    localparam logic [CntW-1:0] CntLast  = CntW'(clks_per_bit - 1);
    localparam logic [PtrW:0]   CntFull  = (PtrW + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

    // Receiver state
    logic            rx_meta, rx_s;
    logic            samp_a, samp_b, vote, at_vote;
    state_e          state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d, cnt_inc;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            push, frame_err_set;
`ifdef UART_RX_PARITY_EN
    logic            parity_bad_q, parity_bad_d;
    logic            parity_err_set;
`endif

    // FIFO state
    logic [7:0]      mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            pop, full, wr_en;
    logic            overflow_q, frame_err_q;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Capture the two samples preceding the vote point
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (clk_cnt_q == CntSampA) samp_a <= rx_s;
            if (clk_cnt_q == CntSampB) samp_b <= rx_s;
        end
    end

    assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign at_vote = (clk_cnt_q == CntVote);
    assign cnt_inc = (clk_cnt_q == CntLast) ? '0 : clk_cnt_q + 1'b1;

    // Receiver FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            clk_cnt_q    <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
`endif
        end
    end

    // Receiver FSM next state. The bit counter keeps running from the start-bit vote, so
    // every later bit is voted at the same offset within its own period.
    always_comb begin
        state_d        = state_q;
        clk_cnt_d      = clk_cnt_q;
        bit_d          = bit_q;
        shift_d        = shift_q;
        push           = 1'b0;
        frame_err_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d   = parity_bad_q;
        parity_err_set = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                parity_bad_d = 1'b0;
`endif
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                clk_cnt_d = cnt_inc;
                if (at_vote) begin
                    if (!vote) begin
                        state_d = StData;
                        bit_d   = '0;
                    end else begin
                        // Too short to be a start bit
                        state_d   = StIdle;
                        clk_cnt_d = '0;
                    end
                end
            end
            StData: begin
                clk_cnt_d = cnt_inc;
                if (at_vote) begin
                    shift_d = {vote, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                clk_cnt_d = cnt_inc;
                if (at_vote) begin
                    state_d = StStop;
                    if (vote != ^shift_q) begin
                        parity_err_set = 1'b1;
                        parity_bad_d   = 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                clk_cnt_d = cnt_inc;
                if (at_vote) begin
                    if (vote) begin
`ifdef UART_RX_PARITY_EN
                        push = !parity_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d   = StIdle;
                        clk_cnt_d = '0;
                    end else begin
                        frame_err_set = 1'b1;
                        state_d       = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold off until the line returns high so a long break reports once
                clk_cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                clk_cnt_d = '0;
            end
        endcase
    end

    // Error pulses are registered one cycle after the deciding vote
    always_ff @(posedge clk) begin
        if (rst) frame_err_q <= 1'b0;
        else     frame_err_q <= frame_err_set;
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    // Parity error pulse register
    always_ff @(posedge clk) begin
        if (rst) parity_err_q <= 1'b0;
        else     parity_err_q <= parity_err_set;
    end

    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_frame_err = frame_err_q;

    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign pop   = i_data_ack && (count_q != '0);
    assign full  = (count_q == CntFull);
    assign wr_en = push && (!full || pop);

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= shift_q;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign o_data_avail = (count_q != '0);
    assign o_databyte   = o_data_avail ? mem[rd_ptr_q] : 8'h00;
    assign o_fifo_count = count_q;
    assign o_overflow   = overflow_q;

endmodule
